register_bank_valid: RTL and testbench
======================================

# register_bank_valid

Parametrised multi-entry successor to the single-word valid register. It holds NrOfRegs words of NrOfBits each, with a per-entry valid flag, tick-qualified writes, global synchronous clear and preset, and a registered read port with an output-select gate. It sits between datapath stages that need a small addressed scratch store, such as feature-map line buffers, and reports entry occupancy to the controlling FSM.

## Interface
- NrOfRegs, 8: number of entries; must be ≥2 and a power of two.
- NrOfBits, 8: width of each entry.
- AddrBits, log2(NrOfRegs): address width; derived, never overridden.
- CntBits, log2(NrOfRegs)+1: width of the ValidCount output.

- Clock  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low; clears all state.
- ClockEnable  in  1  global enable; when low, all state holds.
- Tick  in  1  write qualifier; a write requires ClockEnable & Tick.
- WrEn  in  1  write request.
- WrAddr  in  AddrBits  write entry index.
- D  in  NrOfBits  write data.
- RdEn  in  1  read request; requires ClockEnable only, not Tick.
- RdAddr  in  AddrBits  read entry index.
- Clr  in  1  synchronous clear of every entry and every valid flag.
- Pre  in  1  synchronous preset: every entry becomes all-ones and every valid flag becomes 1.
- Inv  in  1  invalidate: clears the valid flag of entry WrAddr; data is kept.
- Cs  in  1  output deselect; when high, Q is gated (see Configuration).
- Q  out  NrOfBits  registered read data.
- QValid  out  1  valid flag of the entry captured with Q.
- ValidMask  out  NrOfRegs  per-entry valid flags.
- ValidCount  out  CntBits  population count of ValidMask.
- Full  out  1  all entries valid.
- Empty  out  1  no entries valid.

## Operation
- Reset low clears all entries, ValidMask, the Q register, QValid and ValidCount to 0. Empty is 1 and Full is 0.
- Priority per cycle, with ClockEnable high: Clr > Pre > (write / Inv) > hold.
- Clr and Pre act regardless of Tick.
- Write: ClockEnable & Tick & WrEn. Entry[WrAddr] takes D and valid[WrAddr] is set to 1.
- Inv with ClockEnable high and no Clr/Pre: valid[WrAddr] is set to 0.
- Write and Inv in the same cycle: the write wins. Data is stored and valid ends at 1.
- Read: when ClockEnable & RdEn, the Q register takes entry[RdAddr] and QValid takes valid[RdAddr]. Otherwise both hold.
- Read and write to the same address in the same cycle: read-before-write. Q returns the old data and the old valid flag.
- Read in the same cycle as Clr or Pre: Q returns pre-operation contents.
- ValidCount, Full and Empty are combinational from the registered ValidMask.
- Addresses are always in range because NrOfRegs is a power of two; no wrap handling is needed.
- ClockEnable low: no state changes, including Clr and Pre.

## Timing
- Write latency is 1 cycle: data is readable via RdEn on the edge after the write edge, and Q shows it one cycle after that.
- Read latency is 1 cycle from the RdEn edge to Q/QValid.
- ValidMask, ValidCount, Full and Empty update in the same cycle as the write, Inv, Clr or Pre edge.
- Cs is combinational to Q with no latency. QValid is not gated by Cs.
- Reset assertion is asynchronous and immediate.
- Reset deassertion is synchronised externally; the block samples inputs from the first rising edge after deassertion.
- Reset mid-write: the write is lost and every entry reads 0 with valid 0.

## Configuration
- REGISTER_BANK_TRISTATE_EN
  - Defined: Q is driven to high-Z on all bits while Cs is high, for shared-bus use.
  - Undefined (default): Q is forced to all-zeros while Cs is high.
  - In both cases the internal Q register keeps updating regardless of Cs.

## Test plan
- Reset, then write 0x5A to entry 3 with Tick=1, then read entry 3 -> Q=0x5A, QValid=1, ValidCount=1, Empty=0.
- Write to entry 2 with Tick=0, then read entry 2 -> Q=0x00, QValid=0, ValidMask unchanged.
- Pre, then Clr, each for one cycle, then read entry 7 -> after Pre: Full=1, ValidCount=8; after Clr: Empty=1, Q=0x00.
- Entry 4 holds 0x11; write 0x22 and read entry 4 in the same cycle -> Q=0x11; a read on the next cycle -> Q=0x22.
- Write and Inv on entry 5 in the same cycle -> valid[5]=1; Inv alone on the next cycle -> valid[5]=0, and reading entry 5 gives its data with QValid=0.
- Cs=1 after reading 0xFF -> Q=0x00 without the macro, Q=Z with REGISTER_BANK_TRISTATE_EN; Reset pulled low mid-sequence -> all outputs at their reset values immediately.

Source files
------------

// File: rtl/register_bank_valid.sv
// register_bank_valid
//   Small addressed scratch store: NrOfRegs entries of NrOfBits each, every
//   entry carrying a valid flag. Writes are qualified by ClockEnable & Tick,
//   Clr/Pre act on the whole bank, and reads land in a registered Q port.
//   Occupancy (ValidMask/ValidCount/Full/Empty) is reported to the controller.
//
//   Optional feature macro: REGISTER_BANK_TRISTATE_EN
//     defined   : Q is high-Z while Cs is high (shared bus)
//     undefined : Q is forced to zero while Cs is high
//
// Ports
//   Clock       in   rising-edge clock
//   Reset       in   asynchronous active-low reset
//   ClockEnable in   global enable, all state holds when low
//   Tick        in   write qualifier
//   WrEn        in   write request
//   WrAddr      in   write / invalidate entry index
//   D           in   write data
//   RdEn        in   read request (ClockEnable only, no Tick)
//   RdAddr      in   read entry index
//   Clr         in   synchronous clear of all entries and flags
//   Pre         in   synchronous preset (all ones, all valid)
//   Inv         in   invalidate entry WrAddr, data kept
//   Cs          in   output deselect
//   Q           out  registered read data, gated by Cs
//   QValid      out  valid flag captured with Q
//   ValidMask   out  per-entry valid flags
//   ValidCount  out  number of valid entries
//   Full        out  every entry valid
//   Empty       out  no entry valid
module register_bank_valid #(
  parameter int unsigned NrOfRegs = 8,
  parameter int unsigned NrOfBits = 8,
  localparam int unsigned AddrBits = $clog2(NrOfRegs),
  localparam int unsigned CntBits  = $clog2(NrOfRegs) + 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                WrEn,
  input  logic [AddrBits-1:0] WrAddr,
  input  logic [NrOfBits-1:0] D,
  input  logic                RdEn,
  input  logic [AddrBits-1:0] RdAddr,
  input  logic                Clr,
  input  logic                Pre,
  input  logic                Inv,
  input  logic                Cs,
  output logic [NrOfBits-1:0] Q,
  output logic                QValid,
  output logic [NrOfRegs-1:0] ValidMask,
  output logic [CntBits-1:0]  ValidCount,
  output logic                Full,
  output logic                Empty
);

  logic [NrOfBits-1:0] mem [NrOfRegs];
  logic [NrOfRegs-1:0] valid;
  logic [NrOfBits-1:0] q_reg;
  logic                q_valid;
  logic [CntBits-1:0]  count;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < NrOfRegs; i++) mem[i] <= '0;
      valid   <= '0;
      q_reg   <= '0;
      q_valid <= 1'b0;
    end else if (ClockEnable) begin
      // Read samples the pre-edge contents, giving read-before-write and
      // pre-Clr/Pre data without any bypass logic.
      if (RdEn) begin
        q_reg   <= mem[RdAddr];
        q_valid <= valid[RdAddr];
      end
      if (Clr) begin
        for (int unsigned i = 0; i < NrOfRegs; i++) mem[i] <= '0;
        valid <= '0;
      end else if (Pre) begin
        for (int unsigned i = 0; i < NrOfRegs; i++) mem[i] <= '1;
        valid <= '1;
      end else begin
        if (Inv) valid[WrAddr] <= 1'b0;
        // Ordered after Inv so a simultaneous write leaves the flag set.
        if (Tick && WrEn) begin
          mem[WrAddr]   <= D;
          valid[WrAddr] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < NrOfRegs; i++) count = count + CntBits'(valid[i]);
  end

  assign ValidMask  = valid;
  assign ValidCount = count;
  assign Full       = &valid;
  assign Empty      = ~|valid;
  assign QValid     = q_valid;

`ifdef REGISTER_BANK_TRISTATE_EN
  assign Q = Cs ? 'z : q_reg;
`else
  assign Q = Cs ? '0 : q_reg;
`endif

endmodule

// File: tb/tb_register_bank_valid.sv
module tb_register_bank_valid;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       ClockEnable, Tick, WrEn, RdEn, Clr, Pre, Inv, Cs;
  logic [2:0] WrAddr, RdAddr;
  logic [7:0] D;
  logic [7:0] Q;
  logic       QValid;
  logic [7:0] ValidMask;
  logic [3:0] ValidCount;
  logic       Full, Empty;

  int checks = 0;
  int errors = 0;

  register_bank_valid #(.NrOfRegs(8), .NrOfBits(8)) dut (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .WrEn(WrEn), .WrAddr(WrAddr), .D(D), .RdEn(RdEn), .RdAddr(RdAddr),
    .Clr(Clr), .Pre(Pre), .Inv(Inv), .Cs(Cs), .Q(Q), .QValid(QValid),
    .ValidMask(ValidMask), .ValidCount(ValidCount), .Full(Full), .Empty(Empty)
  );

  always #5 Clock = ~Clock;

  // Reference model: plain arrays describing bank contents
  logic [7:0] mm [8];
  logic       vm [8];
  logic [7:0] qm;
  logic       qvm;

  typedef struct {
    logic       ce, tick, we;
    logic [2:0] wa;
    logic [7:0] d;
    logic       re;
    logic [2:0] ra;
    logic       clr, pre, inv;
    logic [7:0] eq;
    logic       eqv;
    logic [7:0] emask;
  } vec_t;

  vec_t vt [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    ClockEnable = 1'b1; Tick = 1'b0; WrEn = 1'b0; RdEn = 1'b0; Clr = 1'b0;
    Pre = 1'b0; Inv = 1'b0; Cs = 1'b0; WrAddr = '0; RdAddr = '0; D = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin mm[i] = '0; vm[i] = 1'b0; end
    qm = '0; qvm = 1'b0;
  endtask

  // One clock edge of the bank as described by its operating rules
  task automatic model_step();
    if (!ClockEnable) return;
    if (RdEn) begin qm = mm[RdAddr]; qvm = vm[RdAddr]; end
    if (Clr) begin
      for (int i = 0; i < 8; i++) begin mm[i] = 8'h00; vm[i] = 1'b0; end
    end else if (Pre) begin
      for (int i = 0; i < 8; i++) begin mm[i] = 8'hFF; vm[i] = 1'b1; end
    end else if (Tick && WrEn) begin
      mm[WrAddr] = D; vm[WrAddr] = 1'b1;
    end else if (Inv) begin
      vm[WrAddr] = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    logic [7:0] emask;
    int         n;
    logic [7:0] eq;
    emask = '0; n = 0;
    for (int i = 0; i < 8; i++) begin emask[i] = vm[i]; n += int'(vm[i]); end
`ifdef REGISTER_BANK_TRISTATE_EN
    eq = Cs ? 8'hzz : qm;
`else
    eq = Cs ? 8'h00 : qm;
`endif
    check({tag, ".Q"}, 32'(Q), 32'(eq));
    check({tag, ".QValid"}, 32'(QValid), 32'(qvm));
    check({tag, ".ValidMask"}, 32'(ValidMask), 32'(emask));
    check({tag, ".ValidCount"}, 32'(ValidCount), 32'(n));
    check({tag, ".Full"}, 32'(Full), 32'(n == 8));
    check({tag, ".Empty"}, 32'(Empty), 32'(n == 0));
  endtask

  initial begin
    // ce tick we wa d re ra clr pre inv | Q QValid ValidMask
    vt[0]  = '{1,1,1,3,8'h5A,0,0,0,0,0, 8'h00,0,8'h08};
    vt[1]  = '{1,0,0,0,8'h00,1,3,0,0,0, 8'h5A,1,8'h08};
    vt[2]  = '{1,0,1,2,8'h77,0,0,0,0,0, 8'h5A,1,8'h08};
    vt[3]  = '{1,0,0,0,8'h00,1,2,0,0,0, 8'h00,0,8'h08};
    vt[4]  = '{1,0,0,0,8'h00,1,7,0,1,0, 8'h00,0,8'hFF};
    vt[5]  = '{1,0,0,0,8'h00,1,7,1,0,0, 8'hFF,1,8'h00};
    vt[6]  = '{1,0,0,0,8'h00,1,7,0,0,0, 8'h00,0,8'h00};
    vt[7]  = '{1,1,1,4,8'h11,0,0,0,0,0, 8'h00,0,8'h10};
    vt[8]  = '{1,1,1,4,8'h22,1,4,0,0,0, 8'h11,1,8'h10};
    vt[9]  = '{1,0,0,0,8'h00,1,4,0,0,0, 8'h22,1,8'h10};
    vt[10] = '{1,1,1,5,8'h33,0,0,0,0,1, 8'h22,1,8'h30};
    vt[11] = '{1,0,0,5,8'h00,0,0,0,0,1, 8'h22,1,8'h10};
    vt[12] = '{1,0,0,0,8'h00,1,5,0,0,0, 8'h33,0,8'h10};
    vt[13] = '{0,1,1,6,8'h99,1,4,1,0,0, 8'h33,0,8'h10};
    vt[14] = '{0,0,0,0,8'h00,0,0,0,1,0, 8'h33,0,8'h10};
    vt[15] = '{1,0,0,4,8'h00,0,0,0,0,1, 8'h33,0,8'h00};

    do_reset();
    #1;
    check("reset.Q", 32'(Q), 32'h0);
    check("reset.QValid", 32'(QValid), 32'h0);
    check("reset.ValidMask", 32'(ValidMask), 32'h0);
    check("reset.ValidCount", 32'(ValidCount), 32'h0);
    check("reset.Empty", 32'(Empty), 32'h1);
    check("reset.Full", 32'(Full), 32'h0);

    for (int i = 0; i < 16; i++) begin
      ClockEnable = vt[i].ce; Tick = vt[i].tick; WrEn = vt[i].we;
      WrAddr = vt[i].wa; D = vt[i].d; RdEn = vt[i].re; RdAddr = vt[i].ra;
      Clr = vt[i].clr; Pre = vt[i].pre; Inv = vt[i].inv; Cs = 1'b0;
      @(posedge Clock); #1;
      check($sformatf("vec%0d.Q", i), 32'(Q), 32'(vt[i].eq));
      check($sformatf("vec%0d.QValid", i), 32'(QValid), 32'(vt[i].eqv));
      check($sformatf("vec%0d.ValidMask", i), 32'(ValidMask), 32'(vt[i].emask));
      check($sformatf("vec%0d.ValidCount", i), 32'(ValidCount), 32'($countones(vt[i].emask)));
      check($sformatf("vec%0d.Full", i), 32'(Full), 32'(vt[i].emask == 8'hFF));
      check($sformatf("vec%0d.Empty", i), 32'(Empty), 32'(vt[i].emask == 8'h00));
    end

    // Output select: gating is immediate and the hidden Q register keeps updating
    idle(); Pre = 1'b1;
    @(posedge Clock); #1;
    idle(); RdEn = 1'b1; RdAddr = 3'd0;
    @(posedge Clock); #1;
    check("cs.read_ff", 32'(Q), 32'hFF);
    idle(); Cs = 1'b1;
    #1;
`ifdef REGISTER_BANK_TRISTATE_EN
    check("cs.gated", 32'(Q), 32'(8'hzz));
`else
    check("cs.gated", 32'(Q), 32'h00);
`endif
    check("cs.qvalid_ungated", 32'(QValid), 32'h1);
    Clr = 1'b1;
    @(posedge Clock); #1;
    Clr = 1'b0; RdEn = 1'b1; RdAddr = 3'd0;
    @(posedge Clock); #1;
    idle();
    #1;
    check("cs.reg_updated", 32'(Q), 32'h00);
    check("cs.qvalid_updated", 32'(QValid), 32'h0);

    // Randomized run against the reference model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ClockEnable = ($urandom_range(0, 9) != 0);
      Tick   = 1'($urandom_range(0, 1));
      WrEn   = 1'($urandom_range(0, 1));
      WrAddr = 3'($urandom_range(0, 7));
      D      = 8'($urandom);
      RdEn   = 1'($urandom_range(0, 1));
      RdAddr = 3'($urandom_range(0, 7));
      Clr    = ($urandom_range(0, 24) == 0);
      Pre    = ($urandom_range(0, 24) == 0);
      Inv    = ($urandom_range(0, 3) == 0);
      Cs     = ($urandom_range(0, 7) == 0);
      @(posedge Clock);
      model_step();
      #1;
      check_model($sformatf("rand%0d", c));
    end

    // Reset asserted mid-write: immediate effect, write lost
    idle(); Pre = 1'b1;
    @(posedge Clock); #1;
    idle(); RdEn = 1'b1; RdAddr = 3'd1;
    @(posedge Clock); #1;
    idle(); Tick = 1'b1; WrEn = 1'b1; WrAddr = 3'd1; D = 8'hAB;
    #2;
    Reset = 1'b0;
    #1;
    check("arst.Q", 32'(Q), 32'h0);
    check("arst.QValid", 32'(QValid), 32'h0);
    check("arst.ValidMask", 32'(ValidMask), 32'h0);
    check("arst.ValidCount", 32'(ValidCount), 32'h0);
    check("arst.Empty", 32'(Empty), 32'h1);
    check("arst.Full", 32'(Full), 32'h0);
    @(negedge Clock);
    idle();
    Reset = 1'b1;
    RdEn = 1'b1; RdAddr = 3'd1;
    @(posedge Clock); #1;
    check("arst.read_Q", 32'(Q), 32'h0);
    check("arst.read_QValid", 32'(QValid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
